// File: rtl/bin2qdi_txenable_1of2_if.sv
// Bit-input handshake for the binary-to-QDI e1of2 transmitter.
// Master drives din/in_valid, slave returns in_ready.
interface bin2qdi_txenable_1of2_if;
   logic din;
   logic in_valid;
   logic in_ready;

   modport master (
      output din,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  din,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/bin2qdi_txenable_1of2.sv
// Clocked e1of2 4-phase token transmitter fed by a small bit FIFO.
// Re is synchronized; R is driven straight from flops so it never glitches.
module bin2qdi_txenable_1of2 #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                    CLK,
   input  logic                    RESET,
   bin2qdi_txenable_1of2_if.slave  in_if,
   input  logic                    txe,
   output logic [1:0]              R,
   input  logic                    Re,
   output logic                    busy,
   output logic [CNT_W-1:0]        tx_count,
   output logic                    err,
   inout  wire                     VDD,
   inout  wire                     GND
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DATA    = 2'd1,
      NEUTRAL = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             r_q, r_d;
   logic                   busy_q, busy_d;
   logic [CNT_W-1:0]       txc_q, txc_d;
   logic                   err_q, err_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   re_prev_q;
   logic                   en_q;
   logic [DEPTH-1:0]       mem_q;
   logic [AW-1:0]          wp_q, wp_d;
   logic [AW-1:0]          rp_q, rp_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic re_s;
   logic re_fall;
   logic full;
   logic empty;
   logic rdy;
   logic push;
   logic pop;
   logic head;

   // Supply pins carry no logic; fold them into a sink.
   wire unused_supply = VDD ^ GND;

   assign re_s    = sync_q[SYNC_STAGES-1];
   assign re_fall = re_prev_q & ~re_s;
   assign full    = (cnt_q == FULL_C);
   assign empty   = (cnt_q == '0);
   assign rdy     = en_q & ~full;
   assign push    = in_if.in_valid & rdy;
   assign head    = mem_q[rp_q];

   assign in_if.in_ready = rdy;
   assign R              = r_q;
   assign busy           = busy_q;
   assign tx_count       = txc_q;
   assign err            = err_q;

   // Re crosses in asynchronously; plain shift-register synchronizer.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync_q    <= '0;
         re_prev_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], Re};
         re_prev_q <= re_s;
      end
   end

   // in_ready stays low until the first edge after reset release.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) en_q <= 1'b0;
      else        en_q <= 1'b1;
   end

   // Next-state for FIFO pointers and occupancy.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage and pointer registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mem_q <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) mem_q[wp_q] <= in_if.din;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Token FSM: issue, wait for ack, return to neutral, wait for ready.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      busy_d  = busy_q;
      txc_d   = txc_q;
      pop     = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (!empty && txe && re_s) begin
               pop     = 1'b1;
               r_d     = head ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
               state_d = DATA;
            end
            if (re_fall) err_d = 1'b1;
         end
         DATA: begin
            if (!re_s) begin
               r_d     = 2'b00;
               state_d = NEUTRAL;
            end
         end
         NEUTRAL: begin
            if (re_s) begin
               busy_d  = 1'b0;
               txc_d   = txc_q + CNT_W'(1);
               state_d = IDLE;
            end
            if (re_fall) err_d = 1'b1;
         end
         default: begin
            r_d     = 2'b00;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // FSM and output registers; reset drops R to neutral at once.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         r_q     <= 2'b00;
         busy_q  <= 1'b0;
         txc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         txc_q   <= txc_d;
         err_q   <= err_d;
      end
   end

endmodule
